// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the alu_sched request sequencer.
// The control struct bundles the per-request datapath settings that travel together.
package alu_sched_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bit positions inside the datapath ALUFlags vector {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [7:0] OPS_MAX = 8'd255;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] shamt;
    logic       dir;
  } ctl_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == OPS_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last_grant pointer is owned by the caller.
// On a tie the requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Arbitrates two requesters onto the shared shift+ALU datapath and returns
// the captured result and flags on a response channel tagged with the requester id.
module alu_sched #(
  parameter int WIDTH = alu_sched_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic [1:0]       req0_shamt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic [1:0]       req1_shamt,
  input  logic             req1_dir,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic [2:0]       dp_alucontrol,
  output logic [1:0]       dp_bshift,
  output logic             dp_select,
  input  logic [WIDTH-1:0] dp_result,
  input  logic [3:0]       dp_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [7:0]       ops_done
);

  import alu_sched_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             last_grant_reg;
  logic             id_reg;
  logic [WIDTH-1:0] dp_a_reg;
  logic [WIDTH-1:0] dp_b_reg;
  ctl_t             dp_ctl_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic [3:0]       rsp_flags_reg;
  logic [7:0]       ops_done_reg;

  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  ctl_t             req_ctl [2];

  assign req_valid  = {req1_valid, req0_valid};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_ctl[0] = {req0_op, req0_shamt, req0_dir};
  assign req_ctl[1] = {req1_op, req1_shamt, req1_dir};

  rr_arb2 u_arb (
    .valid       (req_valid),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Only the granted requester sees ready, and only while idle
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ST_IDLE) && grant_valid && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = (state_reg == ST_IDLE) && grant_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (grant_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      dp_a_reg       <= '0;
      dp_b_reg       <= '0;
      dp_ctl_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
      ops_done_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dp_a_reg       <= req_a[grant_id];
        dp_b_reg       <= req_b[grant_id];
        dp_ctl_reg     <= req_ctl[grant_id];
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
      // The datapath has had the whole EXEC cycle to settle on the held dp_* values
      if (state_reg == ST_EXEC) begin
        rsp_result_reg <= dp_result;
        rsp_flags_reg  <= dp_flags;
      end
      if ((state_reg == ST_RESP) && rsp_ready) begin
        ops_done_reg <= sat_inc(ops_done_reg);
      end
    end
  end

  assign dp_a          = dp_a_reg;
  assign dp_b          = dp_b_reg;
  assign dp_alucontrol = dp_ctl_reg.op;
  assign dp_bshift     = dp_ctl_reg.shamt;
  assign dp_select     = dp_ctl_reg.dir;
  assign rsp_valid     = (state_reg == ST_RESP);
  assign rsp_id        = id_reg;
  assign rsp_result    = rsp_result_reg;
  assign rsp_flags     = rsp_flags_reg;
  assign ops_done      = ops_done_reg;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural shift+ALU datapath.
// Expected results below are hand-computed from the operand vectors.
module tb_alu_sched;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [4:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [1:0] req0_shamt, req1_shamt;
  logic       req0_dir, req1_dir;
  logic [4:0] dp_a, dp_b;
  logic [2:0] dp_alucontrol;
  logic [1:0] dp_bshift;
  logic       dp_select;
  logic [4:0] dp_result;
  logic [3:0] dp_flags;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [4:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [7:0] ops_done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  alu_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_shamt(req0_shamt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_shamt(req1_shamt), .req1_dir(req1_dir),
    .dp_a(dp_a), .dp_b(dp_b), .dp_alucontrol(dp_alucontrol), .dp_bshift(dp_bshift),
    .dp_select(dp_select), .dp_result(dp_result), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: shift a, then add/sub/and/or/xor with b; flags {N,Z,C,V}
  logic [4:0] sh;
  logic [5:0] sum;
  logic       cf, vf;
  always_comb begin
    sh  = dp_select ? (dp_a >> dp_bshift) : (dp_a << dp_bshift);
    sum = 6'd0;
    cf  = 1'b0;
    vf  = 1'b0;
    case (dp_alucontrol)
      3'b000: begin
        sum = {1'b0, sh} + {1'b0, dp_b};
        cf  = sum[5];
        vf  = (sh[4] == dp_b[4]) && (sum[4] != sh[4]);
      end
      3'b001: begin
        sum = {1'b0, sh} + {1'b0, ~dp_b} + 6'd1;
        cf  = sum[5];
        vf  = (sh[4] != dp_b[4]) && (sum[4] != sh[4]);
      end
      3'b010:  sum = {1'b0, sh & dp_b};
      3'b011:  sum = {1'b0, sh | dp_b};
      default: sum = {1'b0, sh ^ dp_b};
    endcase
    dp_result = sum[4:0];
    dp_flags  = {sum[4], (sum[4:0] == 5'd0), cf, vf};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req0(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                          input logic [1:0] shamt, input logic dir);
    req0_a = a; req0_b = b; req0_op = op; req0_shamt = shamt; req0_dir = dir;
  endtask

  task automatic set_req1(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                          input logic [1:0] shamt, input logic dir);
    req1_a = a; req1_b = b; req1_op = op; req1_shamt = shamt; req1_dir = dir;
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmp_cnt++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
        $display("FAIL reset_ctrl cyc=%0d got r0=%b r1=%b rv=%b want 0 0 0", i, req0_ready, req1_ready, rsp_valid);
        err_cnt++;
      end
      cmp_cnt++;
      if ({dp_a, dp_b, dp_alucontrol, dp_bshift, dp_select} !== 16'd0) begin
        $display("FAIL reset_dp cyc=%0d got a=%0d b=%0d op=%0d sh=%0d sel=%0d want all 0",
                 i, dp_a, dp_b, dp_alucontrol, dp_bshift, dp_select);
        err_cnt++;
      end
      cmp_cnt++;
      if ({ops_done, rsp_id, rsp_result, rsp_flags} !== 18'd0) begin
        $display("FAIL reset_rsp cyc=%0d got ops=%0d id=%0d res=%0d fl=%b want all 0",
                 i, ops_done, rsp_id, rsp_result, rsp_flags);
        err_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_single;
    rsp_ready = 1'b0;
    set_req0(5'd3, 5'd4, 3'b000, 2'd1, 1'b0);
    req0_valid = 1'b1;
    #1;
    cmp_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL single_ready got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
      err_cnt++;
    end
    tick();
    req0_valid = 1'b0;
    cmp_cnt++;
    if (dp_a !== 5'd3 || dp_b !== 5'd4 || dp_bshift !== 2'd1 || dp_select !== 1'b0 || dp_alucontrol !== 3'b000) begin
      $display("FAIL single_dp got a=%0d b=%0d sh=%0d sel=%0d op=%0d want 3 4 1 0 0",
               dp_a, dp_b, dp_bshift, dp_select, dp_alucontrol);
      err_cnt++;
    end
    cmp_cnt++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL single_early_rsp got rsp_valid=%b want 0", rsp_valid);
      err_cnt++;
    end
    tick();
    // (3<<1)+4 = 10, no flags
    cmp_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 5'd10 || rsp_flags !== 4'b0000) begin
      $display("FAIL single_rsp got v=%b id=%0d res=%0d fl=%b want 1 0 10 0000",
               rsp_valid, rsp_id, rsp_result, rsp_flags);
      err_cnt++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmp_cnt++;
    if (rsp_valid !== 1'b0 || ops_done !== 8'd1) begin
      $display("FAIL single_done got v=%b ops=%0d want 0 1", rsp_valid, ops_done);
      err_cnt++;
    end
  endtask

  task automatic test_alternate;
    int cyc;
    logic [4:0] exp_res;
    logic [3:0] exp_fl;
    do_reset();
    rsp_ready = 1'b1;
    set_req0(5'd1, 5'd2, 3'b000, 2'd0, 1'b0);
    set_req1(5'd16, 5'd8, 3'b001, 2'd1, 1'b1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!rsp_valid && cyc < 10) begin
        tick();
        cyc++;
      end
      // req0: 1+2=3; req1: (16>>1)-8=0 with carry, zero flag
      exp_res = k[0] ? 5'd0 : 5'd3;
      exp_fl  = k[0] ? 4'b0110 : 4'b0000;
      cmp_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== k[0] || rsp_result !== exp_res || rsp_flags !== exp_fl) begin
        $display("FAIL alt_rsp k=%0d got v=%b id=%0d res=%0d fl=%b want 1 %0d %0d %b",
                 k, rsp_valid, rsp_id, rsp_result, rsp_flags, k[0], exp_res, exp_fl);
        err_cnt++;
      end
      tick();
      cmp_cnt++;
      if (ops_done !== 8'(k + 1)) begin
        $display("FAIL alt_ops k=%0d got %0d want %0d", k, ops_done, k + 1);
        err_cnt++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    set_req1(5'd7, 5'd4, 3'b010, 2'd2, 1'b0);
    req1_valid = 1'b1;
    #1;
    cmp_cnt++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      $display("FAIL bp_grant got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
      err_cnt++;
    end
    tick();
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b1;
    // (7<<2)=28 & 4 = 4
    for (int i = 0; i < 10; i++) begin
      cmp_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 5'd4 || rsp_flags !== 4'b0000) begin
        $display("FAIL bp_hold cyc=%0d got v=%b id=%0d res=%0d fl=%b want 1 1 4 0000",
                 i, rsp_valid, rsp_id, rsp_result, rsp_flags);
        err_cnt++;
      end
      cmp_cnt++;
      if ({req0_ready, req1_ready} !== 2'b00 || dp_a !== 5'd7) begin
        $display("FAIL bp_nogrant cyc=%0d got r0=%b r1=%b dp_a=%0d want 0 0 7",
                 i, req0_ready, req1_ready, dp_a);
        err_cnt++;
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmp_cnt++;
    if (rsp_valid !== 1'b0 || ops_done !== 8'd5 || req0_ready !== 1'b1) begin
      $display("FAIL bp_release got v=%b ops=%0d r0=%b want 0 5 1", rsp_valid, ops_done, req0_ready);
      err_cnt++;
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_reset_inflight;
    rsp_ready = 1'b1;
    set_req0(5'd3, 5'd4, 3'b000, 2'd1, 1'b0);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp_cnt++;
    if (rsp_valid !== 1'b0 || dp_a !== 5'd0 || dp_bshift !== 2'd0) begin
      $display("FAIL rst_exec got v=%b dp_a=%0d sh=%0d want 0 0 0", rsp_valid, dp_a, dp_bshift);
      err_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_cnt++;
      if (rsp_valid !== 1'b0) begin
        $display("FAIL rst_exec_quiet cyc=%0d got v=%b want 0", i, rsp_valid);
        err_cnt++;
      end
    end
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    cmp_cnt++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL rst_resp_pre got v=%b want 1", rsp_valid);
      err_cnt++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp_cnt++;
    if (rsp_valid !== 1'b0 || rsp_result !== 5'd0 || rsp_flags !== 4'd0 || ops_done !== 8'd0) begin
      $display("FAIL rst_resp got v=%b res=%0d fl=%b ops=%0d want 0 0 0000 0",
               rsp_valid, rsp_result, rsp_flags, ops_done);
      err_cnt++;
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    cmp_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL rst_tie got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
      err_cnt++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    int cyc;
    do_reset();
    rsp_ready = 1'b1;
    set_req0(5'd1, 5'd2, 3'b000, 2'd0, 1'b0);
    req0_valid = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 256 && cyc < 2000) begin
      if (rsp_valid) begin
        n++;
        tick();
        if (n == 254 || n == 255) begin
          cmp_cnt++;
          if (ops_done !== 8'(n)) begin
            $display("FAIL b2b_count n=%0d got %0d want %0d", n, ops_done, n);
            err_cnt++;
          end
        end
      end else begin
        tick();
      end
      cyc++;
    end
    req0_valid = 1'b0;
    cmp_cnt++;
    if (n != 256) begin
      $display("FAIL b2b_timeout got %0d responses want 256", n);
      err_cnt++;
    end
    tick();
    cmp_cnt++;
    if (ops_done !== 8'd255) begin
      $display("FAIL b2b_saturate got %0d want 255", ops_done);
      err_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    set_req0(5'd0, 5'd0, 3'd0, 2'd0, 1'b0);
    set_req1(5'd0, 5'd0, 3'd0, 2'd0, 1'b0);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_inflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
